// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp-ADC convert, then
// row-by-row readout streamed over a valid/ready interface.
module pixel_readout_ctrl #(
  parameter int PIXEL_ARRAY_WIDTH  = 3,
  parameter int PIXEL_ARRAY_HEIGHT = 3,
  parameter int PIXEL_BITS         = 8,
  parameter int ERASE_CYCLES       = 4,
  parameter int EXPOSE_WIDTH       = 16
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic                                      continuous,
  input  logic [EXPOSE_WIDTH-1:0]                   expose_cycles,
  output logic                                      pixel_erase,
  output logic                                      pixel_expose,
  output logic                                      pixel_convert,
  output logic [PIXEL_BITS-1:0]                     adc_count,
  output logic                                      pixel_read,
  output logic [PIXEL_ARRAY_HEIGHT-1:0]             row_select,
  input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   pixel_data,
  output logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0]   out_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic                                      out_last,
  output logic                                      busy,
  output logic                                      frame_done
);

  localparam int ROW_W   = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
  localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);
  localparam int CNT_W   = (EXPOSE_WIDTH > ERASE_W) ? EXPOSE_WIDTH : ERASE_W;
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_READ_SEL, S_READ_OUT, S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [EXPOSE_WIDTH-1:0] expose_lat;
  logic [ROW_W-1:0]        row;
  logic                    cnt_zero;
  logic                    adc_max;
  logic                    last_row;

  assign cnt_zero = (cnt == '0);
  assign adc_max  = (adc_count == '1);
  assign last_row = (row == LAST_ROW);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    pixel_erase   = 1'b0;
    pixel_expose  = 1'b0;
    pixel_convert = 1'b0;
    pixel_read    = 1'b0;
    row_select    = '0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    busy          = (state != S_IDLE);
    frame_done    = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_ERASE;
      S_ERASE: begin
        pixel_erase = 1'b1;
        if (cnt_zero) state_nxt = S_EXPOSE;
      end
      S_EXPOSE: begin
        pixel_expose = 1'b1;
        if (cnt_zero) state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        pixel_convert = 1'b1;
        if (adc_max) state_nxt = S_READ_SEL;
      end
      S_READ_SEL: begin
        pixel_read = 1'b1;
        row_select = PIXEL_ARRAY_HEIGHT'(1) << row;
        state_nxt  = S_READ_OUT;
      end
      S_READ_OUT: begin
        pixel_read = 1'b1;
        row_select = PIXEL_ARRAY_HEIGHT'(1) << row;
        out_valid  = 1'b1;
        out_last   = last_row;
        if (out_ready) state_nxt = last_row ? S_DONE : S_READ_SEL;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_nxt  = continuous ? S_ERASE : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // cnt is a shared down-counter: loaded with (length-1) on entry to ERASE
  // and EXPOSE, so a phase ends in the cycle where it reads zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      expose_lat <= '0;
      row        <= '0;
      adc_count  <= '0;
      out_data   <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          expose_lat <= (expose_cycles == '0) ? EXPOSE_WIDTH'(1) : expose_cycles;
          cnt        <= ERASE_LOAD;
          row        <= '0;
        end
        S_ERASE:    cnt <= cnt_zero ? CNT_W'(expose_lat - EXPOSE_WIDTH'(1)) : cnt - CNT_W'(1);
        S_EXPOSE:   if (!cnt_zero) cnt <= cnt - CNT_W'(1);
        // Rolls over to 0 on the max-code cycle, exactly as CONVERT exits.
        S_CONVERT:  adc_count <= adc_count + PIXEL_BITS'(1);
        S_READ_SEL: out_data <= pixel_data;
        S_READ_OUT: if (out_ready && !last_row) row <= row + ROW_W'(1);
        S_DONE: begin
          cnt <= ERASE_LOAD;
          row <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Directed bench for pixel_readout_ctrl: a default 3x3x8 instance and a
// 4-wide, 5-row, 4-bit instance sharing one clock.
module tb_pixel_readout_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (3x3, 8-bit, erase 4, expose width 16)
  logic        a_reset, a_start, a_continuous, a_out_ready;
  logic [15:0] a_expose_cycles;
  logic        a_pixel_erase, a_pixel_expose, a_pixel_convert, a_pixel_read;
  logic [7:0]  a_adc_count;
  logic [2:0]  a_row_select;
  logic [23:0] a_pixel_data, a_out_data;
  logic        a_out_valid, a_out_last, a_busy, a_frame_done;

  // Instance B: 4 pixels per row, 5 rows, 4-bit ADC, erase 2, expose width 8
  logic        b_reset, b_start, b_continuous, b_out_ready;
  logic [7:0]  b_expose_cycles;
  logic        b_pixel_erase, b_pixel_expose, b_pixel_convert, b_pixel_read;
  logic [3:0]  b_adc_count;
  logic [4:0]  b_row_select;
  logic [15:0] b_pixel_data, b_out_data;
  logic        b_out_valid, b_out_last, b_busy, b_frame_done;

  pixel_readout_ctrl dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .continuous(a_continuous),
    .expose_cycles(a_expose_cycles), .pixel_erase(a_pixel_erase),
    .pixel_expose(a_pixel_expose), .pixel_convert(a_pixel_convert),
    .adc_count(a_adc_count), .pixel_read(a_pixel_read), .row_select(a_row_select),
    .pixel_data(a_pixel_data), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last), .busy(a_busy),
    .frame_done(a_frame_done)
  );

  pixel_readout_ctrl #(
    .PIXEL_ARRAY_WIDTH(4), .PIXEL_ARRAY_HEIGHT(5), .PIXEL_BITS(4),
    .ERASE_CYCLES(2), .EXPOSE_WIDTH(8)
  ) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .continuous(b_continuous),
    .expose_cycles(b_expose_cycles), .pixel_erase(b_pixel_erase),
    .pixel_expose(b_pixel_expose), .pixel_convert(b_pixel_convert),
    .adc_count(b_adc_count), .pixel_read(b_pixel_read), .row_select(b_row_select),
    .pixel_data(b_pixel_data), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .busy(b_busy),
    .frame_done(b_frame_done)
  );

  // Sensor model: the selected row presents its row index in every pixel.
  always_comb begin
    a_pixel_data = '0;
    for (int r = 0; r < 3; r++) if (a_row_select[r]) a_pixel_data = {3{8'(r)}};
  end
  always_comb begin
    b_pixel_data = '0;
    for (int r = 0; r < 5; r++) if (b_row_select[r]) b_pixel_data = {4{4'(r)}};
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Per-frame observations gathered by the run tasks.
  int          cyc, n_erase, n_expose, n_convert, n_rows, adc_err, excl_err, hold_err, stalls;
  logic [23:0] rows_data [8];
  logic        rows_last [8];
  logic [23:0] held;
  logic        released;

  // Entered at the falling edge right after the edge that began the frame;
  // returns at the falling edge where frame_done is seen (cyc = latency).
  task automatic run_a(input int stall_row, input int stall_n, input int start_at_adc);
    logic [2:0] stall_sel;
    stall_sel = 3'b001 << stall_row;
    cyc = 0; n_erase = 0; n_expose = 0; n_convert = 0; n_rows = 0;
    adc_err = 0; excl_err = 0; hold_err = 0; stalls = 0; released = 1'b0;
    while (cyc < 2000) begin
      if ($countones({a_pixel_erase, a_pixel_expose, a_pixel_convert, a_pixel_read}) > 1) excl_err++;
      if (a_pixel_erase)  n_erase++;
      if (a_pixel_expose) n_expose++;
      if (a_pixel_convert) begin
        if (a_adc_count !== 8'(n_convert)) adc_err++;
        n_convert++;
      end
      a_start = (start_at_adc >= 0) && a_pixel_convert && (a_adc_count == 8'(start_at_adc));
      if (stalls > 0 && !released &&
          (!a_out_valid || a_row_select !== stall_sel || a_out_data !== held)) hold_err++;
      if (a_out_valid && a_row_select === stall_sel && stalls < stall_n) begin
        if (stalls == 0) held = a_out_data;
        stalls++;
        a_out_ready = 1'b0;
      end else if (a_out_valid) begin
        if (stalls > 0) released = 1'b1;
        a_out_ready = 1'b1;
        if (n_rows < 8) begin
          rows_data[n_rows] = a_out_data;
          rows_last[n_rows] = a_out_last;
        end
        n_rows++;
      end else begin
        a_out_ready = 1'b1;
      end
      if (a_frame_done) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_rows_a(input string tag);
    check({tag, "_nrows"}, n_rows, 3);
    for (int r = 0; r < 3; r++) begin
      check($sformatf("%s_row%0d_data", tag, r), rows_data[r], {3{8'(r)}});
      check($sformatf("%s_row%0d_last", tag, r), rows_last[r], (r == 2));
    end
    check({tag, "_exclusive"}, excl_err, 0);
    check({tag, "_adc_ramp"}, adc_err, 0);
  endtask

  task automatic run_b();
    cyc = 0; n_erase = 0; n_expose = 0; n_convert = 0; n_rows = 0; adc_err = 0; excl_err = 0;
    while (cyc < 2000) begin
      if ($countones({b_pixel_erase, b_pixel_expose, b_pixel_convert, b_pixel_read}) > 1) excl_err++;
      if (b_pixel_erase)  n_erase++;
      if (b_pixel_expose) n_expose++;
      if (b_pixel_convert) begin
        if (b_adc_count !== 4'(n_convert)) adc_err++;
        n_convert++;
      end
      b_start = 1'b0;
      if (b_out_valid) begin
        if (n_rows < 8) begin
          rows_data[n_rows] = {8'h00, b_out_data};
          rows_last[n_rows] = b_out_last;
        end
        n_rows++;
      end
      if (b_frame_done) break;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_rows_b(input string tag);
    check({tag, "_nrows"}, n_rows, 5);
    for (int r = 0; r < 5; r++) begin
      check($sformatf("%s_row%0d_data", tag, r), rows_data[r], {8'h00, {4{4'(r)}}});
      check($sformatf("%s_row%0d_last", tag, r), rows_last[r], (r == 4));
    end
    check({tag, "_exclusive"}, excl_err, 0);
    check({tag, "_adc_ramp"}, adc_err, 0);
  endtask

  initial begin
    int wait_n;
    a_reset = 1'b1; a_start = 1'b0; a_continuous = 1'b0; a_out_ready = 1'b1;
    a_expose_cycles = 16'd0;
    b_reset = 1'b1; b_start = 1'b0; b_continuous = 1'b0; b_out_ready = 1'b1;
    b_expose_cycles = 8'd0;
    repeat (2) @(negedge clk);
    check("a_reset_outputs", {a_pixel_erase, a_pixel_expose, a_pixel_convert, a_adc_count,
          a_pixel_read, a_row_select, a_out_data, a_out_valid, a_out_last, a_busy, a_frame_done}, 0);
    check("b_reset_outputs", {b_pixel_erase, b_pixel_expose, b_pixel_convert, b_adc_count,
          b_pixel_read, b_row_select, b_out_data, b_out_valid, b_out_last, b_busy, b_frame_done}, 0);
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);

    // Baseline frame: expose 10, out_ready held high.
    a_expose_cycles = 16'd10; a_start = 1'b1;
    @(negedge clk);
    run_a(0, 0, -1);
    check("a_base_latency", cyc, 276);
    check("a_base_erase", n_erase, 4);
    check("a_base_expose", n_expose, 10);
    check("a_base_convert", n_convert, 256);
    check_rows_a("a_base");
    @(negedge clk);
    check("a_base_done_pulse", a_frame_done, 0);
    check("a_base_idle", a_busy, 0);

    // Back-pressure: out_ready low for 5 cycles on row 1.
    a_start = 1'b1;
    @(negedge clk);
    run_a(1, 5, -1);
    check("a_stall_latency", cyc, 281);
    check("a_stall_count", stalls, 5);
    check("a_stall_hold", hold_err, 0);
    check_rows_a("a_stall");

    // Zero exposure is one cycle; start during CONVERT is ignored.
    @(negedge clk);
    a_expose_cycles = 16'd0; a_start = 1'b1;
    @(negedge clk);
    run_a(0, 0, 50);
    check("a_exp0_latency", cyc, 267);
    check("a_exp0_expose", n_expose, 1);
    check_rows_a("a_exp0");
    repeat (10) @(negedge clk);
    check("a_exp0_no_second_frame", a_busy, 0);

    // Continuous: two frames, exposure held at the value latched by start.
    a_expose_cycles = 16'd3; a_continuous = 1'b1; a_start = 1'b1;
    @(negedge clk);
    a_expose_cycles = 16'd20;
    run_a(0, 0, -1);
    check("a_cont1_latency", cyc, 269);
    check("a_cont1_expose", n_expose, 3);
    @(negedge clk);
    check("a_cont_erase_after_done", a_pixel_erase, 1);
    check("a_cont_done_pulse", a_frame_done, 0);
    a_continuous = 1'b0;
    run_a(0, 0, -1);
    check("a_cont2_latency", cyc, 269);
    check("a_cont2_expose", n_expose, 3);
    check_rows_a("a_cont2");
    @(negedge clk);
    check("a_cont2_idle", a_busy, 0);

    // Reset mid-CONVERT, then a fresh frame.
    a_expose_cycles = 16'd10; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    wait_n = 0;
    while (a_adc_count != 8'd100 && wait_n < 1000) begin
      @(negedge clk);
      wait_n++;
    end
    check("a_reach_adc100", a_adc_count, 100);
    a_reset = 1'b1;
    @(negedge clk);
    check("a_midreset_outputs", {a_pixel_erase, a_pixel_expose, a_pixel_convert, a_adc_count,
          a_pixel_read, a_row_select, a_out_data, a_out_valid, a_out_last, a_busy, a_frame_done}, 0);
    a_reset = 1'b0;
    repeat (3) @(negedge clk);
    check("a_midreset_stays_idle", {a_busy, a_frame_done}, 0);
    a_start = 1'b1;
    @(negedge clk);
    run_a(0, 0, -1);
    check("a_after_reset_latency", cyc, 276);
    check_rows_a("a_after_reset");

    // Instance B: 5 rows of 4 nibbles, erase 2, expose 3, 16-step ramp.
    b_expose_cycles = 8'd3; b_start = 1'b1;
    @(negedge clk);
    run_b();
    check("b_base_latency", cyc, 31);
    check("b_base_erase", n_erase, 2);
    check("b_base_expose", n_expose, 3);
    check("b_base_convert", n_convert, 16);
    check_rows_b("b_base");

    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    wait_n = 0;
    while (b_adc_count != 4'd10 && wait_n < 200) begin
      @(negedge clk);
      wait_n++;
    end
    check("b_reach_adc10", b_adc_count, 10);
    b_reset = 1'b1;
    @(negedge clk);
    check("b_midreset_outputs", {b_pixel_erase, b_pixel_expose, b_pixel_convert, b_adc_count,
          b_pixel_read, b_row_select, b_out_data, b_out_valid, b_out_last, b_busy, b_frame_done}, 0);
    b_reset = 1'b0;
    @(negedge clk);
    b_expose_cycles = 8'd0; b_start = 1'b1;
    @(negedge clk);
    run_b();
    check("b_after_reset_latency", cyc, 29);
    check("b_after_reset_expose", n_expose, 1);
    check_rows_b("b_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
